seq_multiplier: RTL and testbench

Iterative shift-add multiplier, the multiply-side counterpart of the team's sequential divider. It accepts a multiplicand/multiplier pair on a start pulse and retires one multiplier bit per clock. It then presents a 2*WIDTH-bit product with a one-cycle done pulse. Only `multiplier_size` iterations run, so short operands finish early. It sits beside the divider in the arithmetic unit and uses the same start/done/counter style.

---
 rtl/seq_multiplier.sv | 163 ++++++++++++++++
 tb/tb_seq_multiplier.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, one multiplier bit per clock.
// Define MULT_SIGNED_EN for two's-complement operands with radix-2 Booth recoding.
module seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_multiplicand,
    input  logic [WIDTH-1:0]   i_multiplier,
    input  logic [CW-1:0]      i_multiplier_size,
    output logic [2*WIDTH-1:0] o_product,
    output logic [CW-1:0]      o_count,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] W_CW = CW'(WIDTH);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_m;
    logic [WIDTH:0]       r_acc;
    logic [WIDTH-1:0]     r_q;
    logic [CW-1:0]        r_count;
    logic [CW-1:0]        r_n;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_accept;
    logic                 w_last;
    logic [CW-1:0]        w_count_inc;
    logic [CW-1:0]        w_n_eff;
    logic [CW-1:0]        w_shamt;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_acc_sh;
    logic [WIDTH-1:0]     w_q_sh;
    logic [2*WIDTH-1:0]   w_pq;
    logic [2*WIDTH-1:0]   w_prod;

    // A start is only honoured outside RUN, so operands are never re-captured mid-run.
    assign w_accept    = i_start && (r_state != S_RUN);
    assign w_count_inc = r_count + CW'(1);
    assign w_last      = (w_count_inc == r_n);
    assign w_n_eff     = ((i_multiplier_size == '0) || (i_multiplier_size > W_CW))
                         ? W_CW : i_multiplier_size;
    // Unscanned positions sit below the product; shifting them out right-aligns it.
    assign w_shamt     = W_CW - r_n;
    assign w_q_sh      = {w_sum[0], r_q[WIDTH-1:1]};
    assign w_pq        = {w_acc_sh[WIDTH-1:0], w_q_sh};

`ifdef MULT_SIGNED_EN
    logic           r_qm1;
    logic [WIDTH:0] w_m_ext;

    assign w_m_ext = {r_m[WIDTH-1], r_m};

    // Booth step: bit pair (Q[0], q_-1) selects add, subtract or hold.
    always_comb begin
        w_sum = r_acc;
        unique case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_acc + w_m_ext;
            2'b10:   w_sum = r_acc - w_m_ext;
            default: w_sum = r_acc;
        endcase
    end

    assign w_acc_sh = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign w_prod   = $signed(w_pq) >>> w_shamt;

    // The bit shifted out of Q becomes q_-1 for the next Booth pair.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_qm1 <= 1'b0;
        end else if (w_accept) begin
            r_qm1 <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_qm1 <= r_q[0];
        end
    end
`else
    // Unsigned step: add M when the current multiplier bit is set; carry lands in bit WIDTH.
    always_comb begin
        w_sum = r_acc;
        if (r_q[0]) begin
            w_sum = r_acc + {1'b0, r_m};
        end
    end

    assign w_acc_sh = {1'b0, w_sum[WIDTH:1]};
    assign w_prod   = w_pq >> w_shamt;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = i_start ? S_RUN : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate in RUN, register the product on the last step.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_m       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_count   <= '0;
            r_n       <= W_CW;
            r_product <= '0;
        end else if (w_accept) begin
            r_m       <= i_multiplicand;
            r_acc     <= '0;
            r_q       <= i_multiplier;
            r_count   <= '0;
            r_n       <= w_n_eff;
            r_product <= '0;
        end else if (r_state == S_RUN) begin
            r_acc   <= w_acc_sh;
            r_q     <= w_q_sh;
            r_count <= w_count_inc;
            if (w_last) begin
                r_product <= w_prod;
            end
        end
    end

    assign o_product = r_product;
    assign o_count   = r_count;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed scoreboard bench for seq_multiplier.
// Signed cases run only when MULT_SIGNED_EN is defined.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [5:0]  msize;
    logic [63:0] product;
    logic [5:0]  count;
    logic        busy;
    logic        done;

    typedef struct {
        logic [63:0] prod;
        logic [63:0] cnt;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    seq_multiplier #(.WIDTH(32), .CW(6)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_start          (start),
        .i_multiplicand   (mcand),
        .i_multiplier     (mplier),
        .i_multiplier_size(msize),
        .o_product        (product),
        .o_count          (count),
        .o_busy           (busy),
        .o_done           (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_size(input logic [5:0] s);
        return ((s == 6'd0) || (s > 6'd32)) ? 32 : int'(s);
    endfunction

    // Reference product: multiplier truncated to N bits, unsigned or sign-extended.
    function automatic logic [63:0] model(input logic [31:0] m, input logic [31:0] y,
                                          input logic [5:0] s);
        int          n;
        logic [63:0] t;
        n = eff_size(s);
        t = {32'b0, y} << (64 - n);
`ifdef MULT_SIGNED_EN
        t = $signed(t) >>> (64 - n);
        return $signed({{32{m[31]}}, m}) * $signed(t);
`else
        t = t >> (64 - n);
        return {32'b0, m} * t;
`endif
    endfunction

    task automatic drive(input logic [31:0] m, input logic [31:0] y, input logic [5:0] s);
        exp_t e;
        mcand  = m;
        mplier = y;
        msize  = s;
        start  = 1'b1;
        e.prod = model(m, y, s);
        e.cnt  = 64'(eff_size(s));
        e.lat  = eff_size(s) + 1;
        sb.push_back(e);
    endtask

    // Waits for done, counting edges from the accepting edge (which counts as 1).
    task automatic finish_op(input string tag);
        int   lat;
        bit   seen;
        exp_t e;
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            lat++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_latency"}, 64'(lat), 64'(e.lat));
            check({tag, "_product"}, product, e.prod);
            check({tag, "_count"}, 64'(count), e.cnt);
            check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] y,
                          input logic [5:0] s);
        drive(m, y, s);
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        finish_op(tag);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        msize  = '0;
        repeat (2) tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", product, 64'd0);
        check("reset_count", 64'(count), 64'd0);
        rst = 1'b0;
        tick();

        run_op("basic", 32'd67, 32'd14, 6'd4);
        tick();
        check("hold_done", 64'(done), 64'd0);
        check("hold_product", product, 64'd938);
        check("hold_count", 64'(count), 64'd4);

        run_op("full", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd0);
        run_op("oversize", 32'd3, 32'd5, 6'd40);
        run_op("hibits", 32'd10, 32'h0000_00F3, 6'd4);
        tick();

        drive(32'd67, 32'd14, 6'd4);
        tick();
        mcand  = 32'd9;
        mplier = 32'd9;
        msize  = 6'd4;
        finish_op("busy_first");
        drive(32'd9, 32'd9, 6'd4);
        tick();
        start = 1'b0;
        check("rerun_busy", 64'(busy), 64'd1);
        check("rerun_done", 64'(done), 64'd0);
        finish_op("rerun");
        tick();

        mcand  = 32'd67;
        mplier = 32'd14;
        msize  = 6'd4;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_product", product, 64'd0);
        check("abort_count", 64'(count), 64'd0);
        repeat (4) tick();
        check("abort_no_done", 64'(done), 64'd0);
        run_op("fresh", 32'd5, 32'd3, 6'd4);
        tick();

`ifdef MULT_SIGNED_EN
        run_op("neg7x5", 32'hFFFF_FFF9, 32'd5, 6'd4);
        run_op("6xneg3", 32'd6, 32'h0000_000D, 6'd4);
        run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 6'd0);
        tick();
`endif

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
